int_wb_arbiter: RTL and testbench

Collects completed integer micro-ops from up to NUM_SRC execution units and drives the two writeback broadcast ports (writeback0/writeback1). The integer issue queue consumes these ports for operand wakeup, and the physical regfile and ROB consume them for completion. Each source has a one-entry holding slot with a valid/ready handshake and round-robin selection of up to two slots per cycle. Entries younger than a flush are squashed.

---
 rtl/int_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_int_wb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: one holding slot per execution unit, two round-robin
// writeback ports, flush squash by ROB age. Define INT_WB_BYPASS_EN for same-cycle bypass.
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 6
`endif

module int_wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_SRC-1:0]                    src_valid,
  output logic [NUM_SRC-1:0]                    src_ready,
  input  logic [NUM_SRC-1:0]                    src_need_to_wb,
  input  logic [NUM_SRC-1:0][`PREG_RANGE]       src_prd,
  input  logic [NUM_SRC-1:0][`INSTR_ID_WIDTH:0] src_robid,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    src_data,
  output logic                                  writeback0_valid,
  output logic                                  writeback0_need_to_wb,
  output logic [`PREG_RANGE]                    writeback0_prd,
  output logic [`INSTR_ID_WIDTH:0]              writeback0_robid,
  output logic [DATA_WIDTH-1:0]                 writeback0_data,
  output logic                                  writeback1_valid,
  output logic                                  writeback1_need_to_wb,
  output logic [`PREG_RANGE]                    writeback1_prd,
  output logic [`INSTR_ID_WIDTH:0]              writeback1_robid,
  output logic [DATA_WIDTH-1:0]                 writeback1_data,
  input  logic                                  flush_valid,
  input  logic [`INSTR_ID_WIDTH:0]              flush_robid
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef logic [`PREG_RANGE]       prd_t;
  typedef logic [`INSTR_ID_WIDTH:0] robid_t;
  typedef logic [PTR_W-1:0]         ptr_t;

  // Wrap bit equal: larger index is younger. Wrap bit differs: smaller index is younger.
  function automatic logic is_younger(input robid_t id, input robid_t flush_id);
    logic [`INSTR_ID_WIDTH-1:0] id_idx;
    logic [`INSTR_ID_WIDTH-1:0] fl_idx;
    id_idx = id[`INSTR_ID_WIDTH-1:0];
    fl_idx = flush_id[`INSTR_ID_WIDTH-1:0];
    if (id[`INSTR_ID_WIDTH] == flush_id[`INSTR_ID_WIDTH]) begin
      return (id_idx > fl_idx);
    end else begin
      return (id_idx < fl_idx);
    end
  endfunction

  function automatic ptr_t wrap_add(input ptr_t base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM_SRC) begin
      sum = sum - NUM_SRC;
    end else begin
      sum = sum;
    end
    return ptr_t'(sum);
  endfunction

  logic [NUM_SRC-1:0]    slot_valid_r;
  logic [NUM_SRC-1:0]    slot_need_r;
  prd_t                  slot_prd_r   [NUM_SRC];
  robid_t                slot_robid_r [NUM_SRC];
  logic [DATA_WIDTH-1:0] slot_data_r  [NUM_SRC];
  ptr_t                  rr_ptr_r;

  logic [NUM_SRC-1:0]    slot_kill_s;
  logic [NUM_SRC-1:0]    in_kill_s;
  logic [NUM_SRC-1:0]    slot_cand_s;
  logic [NUM_SRC-1:0]    slot_grant_s;
  logic [NUM_SRC-1:0]    hs_s;
  logic [NUM_SRC-1:0]    slot_take_s;
  logic [1:0]            sel_found_s;
  ptr_t                  sel_idx_s    [2];
  logic [1:0]            hit_cnt_s;
  ptr_t                  scan_idx_s;
  ptr_t                  last_idx_s;
  logic                  pick_need_s  [2];
  prd_t                  pick_prd_s   [2];
  robid_t                pick_robid_s [2];
  logic [DATA_WIDTH-1:0] pick_data_s  [2];
`ifdef INT_WB_BYPASS_EN
  logic [NUM_SRC-1:0]    byp_cand_s;
  logic [NUM_SRC-1:0]    byp_grant_s;
  logic [1:0]            sel_byp_s;
`endif

  // Flush age checks for stored slots and for incoming payloads.
  always_comb begin
    slot_kill_s = '0;
    in_kill_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flush_valid) begin
        slot_kill_s[i] = slot_valid_r[i] & is_younger(slot_robid_r[i], flush_robid);
        in_kill_s[i]   = is_younger(src_robid[i], flush_robid);
      end else begin
        slot_kill_s[i] = 1'b0;
        in_kill_s[i]   = 1'b0;
      end
    end
  end

  assign slot_cand_s = slot_valid_r & ~slot_kill_s;
  assign src_ready   = reset_n ? (~slot_valid_r | slot_grant_s) : '0;
  assign hs_s        = src_valid & src_ready;
`ifdef INT_WB_BYPASS_EN
  assign byp_cand_s  = src_valid & ~slot_valid_r & ~in_kill_s;
  assign slot_take_s = hs_s & ~in_kill_s & ~byp_grant_s;
`else
  assign slot_take_s = hs_s & ~in_kill_s;
`endif

  // Round-robin scan from rr_ptr: first hit -> port 0, second hit -> port 1.
  always_comb begin
    sel_found_s  = 2'b00;
    sel_idx_s[0] = '0;
    sel_idx_s[1] = '0;
    slot_grant_s = '0;
    hit_cnt_s    = 2'd0;
    scan_idx_s   = '0;
`ifdef INT_WB_BYPASS_EN
    sel_byp_s    = 2'b00;
    byp_grant_s  = '0;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx_s = wrap_add(rr_ptr_r, k);
      if (slot_cand_s[scan_idx_s] && (hit_cnt_s != 2'd2)) begin
        sel_found_s[hit_cnt_s[0]] = 1'b1;
        sel_idx_s[hit_cnt_s[0]]   = scan_idx_s;
        slot_grant_s[scan_idx_s]  = 1'b1;
        hit_cnt_s                 = hit_cnt_s + 2'd1;
      end else begin
        hit_cnt_s = hit_cnt_s;
      end
    end
`ifdef INT_WB_BYPASS_EN
    // Bypass candidates only fill ports left over after every stored slot.
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx_s = wrap_add(rr_ptr_r, k);
      if (byp_cand_s[scan_idx_s] && (hit_cnt_s != 2'd2)) begin
        sel_found_s[hit_cnt_s[0]] = 1'b1;
        sel_byp_s[hit_cnt_s[0]]   = 1'b1;
        sel_idx_s[hit_cnt_s[0]]   = scan_idx_s;
        byp_grant_s[scan_idx_s]   = 1'b1;
        hit_cnt_s                 = hit_cnt_s + 2'd1;
      end else begin
        hit_cnt_s = hit_cnt_s;
      end
    end
`endif
  end

  assign last_idx_s = sel_found_s[1] ? sel_idx_s[1] : sel_idx_s[0];

  // Payload mux for each writeback port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pick_need_s[p]  = 1'b0;
      pick_prd_s[p]   = '0;
      pick_robid_s[p] = '0;
      pick_data_s[p]  = '0;
`ifdef INT_WB_BYPASS_EN
      if (sel_byp_s[p]) begin
        pick_need_s[p]  = src_need_to_wb[sel_idx_s[p]];
        pick_prd_s[p]   = src_prd[sel_idx_s[p]];
        pick_robid_s[p] = src_robid[sel_idx_s[p]];
        pick_data_s[p]  = src_data[sel_idx_s[p]];
      end else begin
        pick_need_s[p]  = slot_need_r[sel_idx_s[p]];
        pick_prd_s[p]   = slot_prd_r[sel_idx_s[p]];
        pick_robid_s[p] = slot_robid_r[sel_idx_s[p]];
        pick_data_s[p]  = slot_data_r[sel_idx_s[p]];
      end
`else
      pick_need_s[p]  = slot_need_r[sel_idx_s[p]];
      pick_prd_s[p]   = slot_prd_r[sel_idx_s[p]];
      pick_robid_s[p] = slot_robid_r[sel_idx_s[p]];
      pick_data_s[p]  = slot_data_r[sel_idx_s[p]];
`endif
    end
  end

  // Slot storage: refill on accepted handshake, otherwise clear on grant or flush kill.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_valid_r <= '0;
      slot_need_r  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_prd_r[i]   <= '0;
        slot_robid_r[i] <= '0;
        slot_data_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (slot_take_s[i]) begin
          slot_valid_r[i] <= 1'b1;
          slot_need_r[i]  <= src_need_to_wb[i];
          slot_prd_r[i]   <= src_prd[i];
          slot_robid_r[i] <= src_robid[i];
          slot_data_r[i]  <= src_data[i];
        end else if (slot_grant_s[i] || slot_kill_s[i]) begin
          slot_valid_r[i] <= 1'b0;
        end else begin
          slot_valid_r[i] <= slot_valid_r[i];
        end
      end
    end
  end

  // Round-robin pointer moves past the last granted source.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_r <= '0;
    end else if (sel_found_s[0]) begin
      rr_ptr_r <= wrap_add(last_idx_s, 1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Registered writeback broadcast; idle ports drive zero payload.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      writeback0_valid      <= 1'b0;
      writeback0_need_to_wb <= 1'b0;
      writeback0_prd        <= '0;
      writeback0_robid      <= '0;
      writeback0_data       <= '0;
      writeback1_valid      <= 1'b0;
      writeback1_need_to_wb <= 1'b0;
      writeback1_prd        <= '0;
      writeback1_robid      <= '0;
      writeback1_data       <= '0;
    end else begin
      writeback0_valid      <= sel_found_s[0];
      writeback0_need_to_wb <= sel_found_s[0] ? pick_need_s[0]  : 1'b0;
      writeback0_prd        <= sel_found_s[0] ? pick_prd_s[0]   : '0;
      writeback0_robid      <= sel_found_s[0] ? pick_robid_s[0] : '0;
      writeback0_data       <= sel_found_s[0] ? pick_data_s[0]  : '0;
      writeback1_valid      <= sel_found_s[1];
      writeback1_need_to_wb <= sel_found_s[1] ? pick_need_s[1]  : 1'b0;
      writeback1_prd        <= sel_found_s[1] ? pick_prd_s[1]   : '0;
      writeback1_robid      <= sel_found_s[1] ? pick_robid_s[1] : '0;
      writeback1_data       <= sel_found_s[1] ? pick_data_s[1]  : '0;
    end
  end

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Self-checking bench for int_wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations on the writeback ports.
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 6
`endif

module tb_int_wb_arbiter;
  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int IW   = `INSTR_ID_WIDTH;
  localparam int SPAN = 1 << (IW + 1);

  typedef logic [`PREG_RANGE] prd_t;
  typedef logic [IW:0]        rob_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset_n;
  logic [N-1:0]          src_valid;
  logic [N-1:0]          src_ready;
  logic [N-1:0]          src_need_to_wb;
  logic [N-1:0][`PREG_RANGE] src_prd;
  logic [N-1:0][IW:0]    src_robid;
  logic [N-1:0][DW-1:0]  src_data;
  logic                  writeback0_valid, writeback0_need_to_wb;
  prd_t                  writeback0_prd;
  rob_t                  writeback0_robid;
  logic [DW-1:0]         writeback0_data;
  logic                  writeback1_valid, writeback1_need_to_wb;
  prd_t                  writeback1_prd;
  rob_t                  writeback1_robid;
  logic [DW-1:0]         writeback1_data;
  logic                  flush_valid;
  rob_t                  flush_robid;

  int_wb_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_need_to_wb(src_need_to_wb),
    .src_prd(src_prd), .src_robid(src_robid), .src_data(src_data),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd), .writeback0_robid(writeback0_robid),
    .writeback0_data(writeback0_data),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd), .writeback1_robid(writeback1_robid),
    .writeback1_data(writeback1_data),
    .flush_valid(flush_valid), .flush_robid(flush_robid)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: slot contents, round-robin start, last handshake per source.
  bit            m_v [N];
  bit            m_n [N];
  prd_t          m_p [N];
  rob_t          m_r [N];
  logic [DW-1:0] m_d [N];
  int            m_ptr = 0;
  bit            last_hs [N];

  logic [DW-1:0] obs_d [$];
  rob_t          obs_r [$];
  int            obs_c [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Distance from the flush id around the ROB ring: 1..SPAN/2-1 means younger.
  function automatic bit m_younger(input rob_t id, input rob_t f);
    int diff;
    diff = (int'(id) - int'(f) + SPAN) % SPAN;
    return (diff > 0) && (diff < SPAN / 2);
  endfunction

  function automatic int count_rob(input rob_t r);
    int c = 0;
    foreach (obs_r[j]) if (obs_r[j] == r) c++;
    return c;
  endfunction

  task automatic cycle();
    bit            exp_rdy [N];
    bit            sgrant [N];
    bit            bgrant [N];
    bit            kill_s [N];
    bit            kill_in [N];
    int            pk_src [$];
    bit            pk_byp [$];
    bit            ev [2];
    bit            en [2];
    prd_t          ep [2];
    rob_t          er [2];
    logic [DW-1:0] ed [2];
    int            idx;
    int            s;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      sgrant[i]  = 0;
      bgrant[i]  = 0;
      kill_s[i]  = flush_valid && m_v[i] && m_younger(m_r[i], flush_robid);
      kill_in[i] = flush_valid && m_younger(src_robid[i], flush_robid);
    end
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (m_v[idx] && !kill_s[idx]) begin pk_src.push_back(idx); pk_byp.push_back(1'b0); end
    end
`ifdef INT_WB_BYPASS_EN
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (src_valid[idx] && !m_v[idx] && !kill_in[idx]) begin pk_src.push_back(idx); pk_byp.push_back(1'b1); end
    end
`endif
    for (int p = 0; p < 2; p++) begin
      ev[p] = 0; en[p] = 0; ep[p] = '0; er[p] = '0; ed[p] = '0;
      if (p < pk_src.size() && reset_n) begin
        s = pk_src[p];
        ev[p] = 1;
        if (pk_byp[p]) begin
          bgrant[s] = 1;
          en[p] = src_need_to_wb[s]; ep[p] = src_prd[s]; er[p] = src_robid[s]; ed[p] = src_data[s];
        end else begin
          sgrant[s] = 1;
          en[p] = m_n[s]; ep[p] = m_p[s]; er[p] = m_r[s]; ed[p] = m_d[s];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_rdy[i] = reset_n && (!m_v[i] || sgrant[i]);
      chk($sformatf("src_ready[%0d]", i), src_ready[i], exp_rdy[i]);
    end
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin m_v[i] = 0; last_hs[i] = 0; end
    end else begin
      if (pk_src.size() > 0) m_ptr = (pk_src[(pk_src.size() > 1) ? 1 : 0] + 1) % N;
      for (int i = 0; i < N; i++) begin
        last_hs[i] = src_valid[i] && exp_rdy[i];
        if (sgrant[i] || kill_s[i]) m_v[i] = 0;
        if (last_hs[i] && !kill_in[i] && !bgrant[i]) begin
          m_v[i] = 1; m_n[i] = src_need_to_wb[i]; m_p[i] = src_prd[i];
          m_r[i] = src_robid[i]; m_d[i] = src_data[i];
        end
      end
    end
    #1;
    chk("wb0_valid", writeback0_valid, ev[0]);
    chk("wb0_need", writeback0_need_to_wb, en[0]);
    chk("wb0_prd", writeback0_prd, ep[0]);
    chk("wb0_robid", writeback0_robid, er[0]);
    chk("wb0_data", writeback0_data, ed[0]);
    chk("wb1_valid", writeback1_valid, ev[1]);
    chk("wb1_need", writeback1_need_to_wb, en[1]);
    chk("wb1_prd", writeback1_prd, ep[1]);
    chk("wb1_robid", writeback1_robid, er[1]);
    chk("wb1_data", writeback1_data, ed[1]);
    if (writeback0_valid) begin obs_d.push_back(writeback0_data); obs_r.push_back(writeback0_robid); obs_c.push_back(cyc); end
    if (writeback1_valid) begin obs_d.push_back(writeback1_data); obs_r.push_back(writeback1_robid); obs_c.push_back(cyc); end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; src_valid = '0; flush_valid = 1'b0;
    cycle();
    cycle();
    chk("rst_wb0_valid", writeback0_valid, 1'b0);
    chk("rst_wb0_data", writeback0_data, 64'h0);
    chk("rst_wb1_valid", writeback1_valid, 1'b0);
    chk("rst_ready", src_ready, 4'h0);
    reset_n = 1'b1;
    obs_d.delete(); obs_r.delete(); obs_c.delete();
  endtask

  task automatic set_src(input int s, input bit need, input prd_t p, input rob_t r, input logic [DW-1:0] d);
    src_valid[s] = 1'b1; src_need_to_wb[s] = need; src_prd[s] = p; src_robid[s] = r; src_data[s] = d;
  endtask

  int seq [3];
  int cnt_obs, last_c, max_gap;
  bit in_order;

  initial begin
    reset_n = 1'b0; src_valid = '0; src_need_to_wb = '0; src_prd = '0;
    src_robid = '0; src_data = '0; flush_valid = 1'b0; flush_robid = '0;

    // Single source latency
    do_reset();
    set_src(1, 1'b1, 6'd12, 7'h05, 64'hA5);
    cycle();
    src_valid = '0;
`ifndef INT_WB_BYPASS_EN
    chk("lat_not_early", writeback0_valid, 1'b0);
    cycle();
`endif
    chk("single_valid", writeback0_valid, 1'b1);
    chk("single_prd", writeback0_prd, 6'd12);
    chk("single_robid", writeback0_robid, 7'h05);
    chk("single_data", writeback0_data, 64'hA5);
    chk("single_need", writeback0_need_to_wb, 1'b1);
    chk("single_wb1", writeback1_valid, 1'b0);
    cycle();

    // All four sources at once, then round-robin restart at 0
    do_reset();
    for (int s = 0; s < N; s++) set_src(s, 1'b1, prd_t'(s + 1), rob_t'(16 + s), 64'h100 + 64'(s));
    cycle();
    src_valid = '0;
`ifndef INT_WB_BYPASS_EN
    cycle();
`endif
    chk("all4_a_wb0", writeback0_data, 64'h100);
    chk("all4_a_wb1", writeback1_data, 64'h101);
    cycle();
    chk("all4_b_wb0", writeback0_data, 64'h102);
    chk("all4_b_wb1", writeback1_data, 64'h103);
    cycle();
    chk("all4_idle", writeback0_valid, 1'b0);
    set_src(0, 1'b1, 6'd1, 7'h20, 64'h200);
    set_src(3, 1'b1, 6'd4, 7'h23, 64'h203);
    cycle();
    src_valid = '0;
`ifndef INT_WB_BYPASS_EN
    cycle();
`endif
    chk("rr_wrap_wb0", writeback0_data, 64'h200);
    chk("rr_wrap_wb1", writeback1_data, 64'h203);
    cycle();

    // Backpressure: sources 0..2 continuously valid
    do_reset();
    for (int s = 0; s < 3; s++) seq[s] = 0;
    for (int c = 0; c < 24; c++) begin
      for (int s = 0; s < 3; s++)
        set_src(s, 1'b1, prd_t'(s + 1), rob_t'(seq[s] % 32), (64'(s) << 32) | 64'(seq[s]));
      cycle();
      for (int s = 0; s < 3; s++) if (last_hs[s]) seq[s]++;
    end
    src_valid = '0;
    for (int c = 0; c < 4; c++) cycle();
    for (int s = 0; s < 3; s++) begin
      cnt_obs = 0; in_order = 1'b1; last_c = -1; max_gap = 0;
      foreach (obs_d[j]) begin
        if (int'(obs_d[j][39:32]) == s) begin
          if (int'(obs_d[j][31:0]) != cnt_obs) in_order = 1'b0;
          if (last_c >= 0 && obs_c[j] - last_c > max_gap) max_gap = obs_c[j] - last_c;
          last_c = obs_c[j];
          cnt_obs++;
        end
      end
      chk($sformatf("bp_count_src%0d", s), cnt_obs, seq[s]);
      chk($sformatf("bp_order_src%0d", s), in_order, 1'b1);
      chk($sformatf("bp_gap_src%0d", s), (max_gap <= 2), 1'b1);
      chk($sformatf("bp_progress_src%0d", s), (seq[s] >= 12), 1'b1);
    end

    // Flush kills slot younger than 0x08; equal survives; incoming 0x0C discarded
    do_reset();
    set_src(0, 1'b1, 6'd1, 7'h03, 64'h303);
    set_src(1, 1'b1, 6'd2, 7'h08, 64'h308);
    set_src(2, 1'b1, 6'd3, 7'h0A, 64'h30A);
    cycle();
    src_valid = '0;
    flush_valid = 1'b1; flush_robid = 7'h08;
    set_src(3, 1'b1, 6'd4, 7'h0C, 64'h30C);
    cycle();
    src_valid = '0; flush_valid = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk("flush_keep_03", count_rob(7'h03), 1);
    chk("flush_keep_08", count_rob(7'h08), 1);
    chk("flush_drop_0A", count_rob(7'h0A), 0);
    chk("flush_drop_in_0C", count_rob(7'h0C), 0);

    // Wrap-around flush at 0x7E: 0x01 (wrapped, younger) dies, 0x7D and 0x7E survive
    do_reset();
    set_src(0, 1'b1, 6'd1, 7'h7D, 64'h47D);
    set_src(1, 1'b1, 6'd2, 7'h7E, 64'h47E);
    set_src(2, 1'b1, 6'd3, 7'h01, 64'h401);
    cycle();
    src_valid = '0;
    flush_valid = 1'b1; flush_robid = 7'h7E;
    cycle();
    flush_valid = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk("wrap_keep_7D", count_rob(7'h7D), 1);
    chk("wrap_keep_7E", count_rob(7'h7E), 1);
    chk("wrap_drop_01", count_rob(7'h01), 0);

    // need_to_wb = 0 still takes writeback0
    do_reset();
    set_src(0, 1'b0, 6'd3, 7'h11, 64'h77);
    cycle();
    src_valid = '0;
`ifndef INT_WB_BYPASS_EN
    cycle();
`endif
    chk("nowb_valid", writeback0_valid, 1'b1);
    chk("nowb_need", writeback0_need_to_wb, 1'b0);
    chk("nowb_data", writeback0_data, 64'h77);
    cycle();

    // Reset mid-operation with a coincident flush: entries lost, outputs zero
    do_reset();
    for (int s = 0; s < N; s++) set_src(s, 1'b1, prd_t'(s), rob_t'(s + 2), 64'h500 + 64'(s));
    cycle();
    src_valid = '0;
    reset_n = 1'b0; flush_valid = 1'b1; flush_robid = 7'h00;
    cycle();
    chk("midrst_wb0", writeback0_valid, 1'b0);
    chk("midrst_wb1", writeback1_valid, 1'b0);
    chk("midrst_data", writeback0_data, 64'h0);
    reset_n = 1'b1; flush_valid = 1'b0;
    cycle();
    cycle();
    chk("midrst_lost", writeback0_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
